banked_req_memory: RTL and testbench

- Parametrised successor to the single-request main memory: a word-addressed, byte-enabled memory behind a request queue.
- Accepts one read or write per cycle while the queue has room and executes requests strictly in order with a programmable access latency.
- Holds each response until the consumer accepts it and flags out-of-range addresses.
- Sits between the vector load/store unit and backing storage.

---
 rtl/banked_req_memory.sv | 230 +++++++++++++++++++++++
 tb/tb_banked_req_memory.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_req_memory.sv
// Word-addressed, byte-enabled memory behind an in-order request queue.
// A single engine pops requests, spends ACCESS_LATENCY cycles per access,
// and holds each response until the consumer accepts it.
module banked_req_memory #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int ID_WIDTH       = 4,
  parameter int QUEUE_DEPTH    = 4,
  parameter int ACCESS_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_write,
  input  logic                          req_read,
  input  logic [ID_WIDTH-1:0]           req_id,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH/8-1:0]       req_byte_en,
  input  logic [DATA_WIDTH-1:0]         req_write_data,
  output logic                          mem_ready,
  output logic                          req_latched,
  output logic                          rsp_write,
  output logic                          rsp_read,
  output logic                          rsp_err,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_read_data,
  input  logic                          rsp_ready,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

  // Range limit widened by one bit so MEM_DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                  is_write;
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_W-1:0]       byte_en;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  // Request queue
  req_t             queue_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push;
  logic             pop;
  logic             queue_empty;
  req_t             head;

  // Engine
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             cur_q, cur_d;

  // Registered response
  logic                  rsp_write_q, rsp_write_d;
  logic                  rsp_read_q, rsp_read_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Backing storage
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  in_range;

  assign mem_ready   = (count_q < (PTR_W+1)'(QUEUE_DEPTH)) && !reset;
  assign req_latched = (req_write ^ req_read) && mem_ready;
  assign push        = req_latched;
  assign queue_empty = (count_q == '0);
  assign head        = queue_q[rd_ptr_q];

  assign mem_idx   = cur_q.addr[IDX_W-1:0];
  assign mem_rdata = mem_q[mem_idx];
  assign in_range  = ({1'b0, cur_q.addr} < DEPTH_LIMIT);

  assign queue_count   = count_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_read      = rsp_read_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_read_data = rsp_data_q;

  // Store an accepted request at the tail of the queue.
  // NOTE: storage arrays carry no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      queue_q[wr_ptr_q] <= '{is_write: req_write,
                             id:       req_id,
                             addr:     req_addr,
                             byte_en:  req_byte_en,
                             wdata:    req_write_data};
    end
  end

  // Queue pointer and occupancy bookkeeping; push and pop together leave the count unchanged.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Merge enabled write bytes over the current word.
  always_comb begin
    mem_wdata = mem_rdata;
    for (int i = 0; i < BE_W; i++) begin
      if (cur_q.byte_en[i]) mem_wdata[i*8 +: 8] = cur_q.wdata[i*8 +: 8];
    end
  end

  // Engine next-state: pop, count down the access latency, then hold the response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    rsp_write_d = rsp_write_q;
    rsp_read_d  = rsp_read_q;
    rsp_err_d   = rsp_err_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!queue_empty) begin
          pop     = 1'b1;
          cur_d   = head;
          cnt_d   = CNT_W'(ACCESS_LATENCY - 1);
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (cnt_q == '0) begin
          mem_we      = cur_q.is_write && in_range;
          rsp_write_d = cur_q.is_write;
          rsp_read_d  = !cur_q.is_write;
          rsp_err_d   = !in_range;
          rsp_id_d    = cur_q.id;
          rsp_data_d  = (!cur_q.is_write && in_range) ? mem_rdata : '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          // Response consumed: clear it whether or not another request follows.
          rsp_write_d = 1'b0;
          rsp_read_d  = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_id_d    = '0;
          rsp_data_d  = '0;
          if (!queue_empty) begin
            pop     = 1'b1;
            cur_d   = head;
            cnt_d   = CNT_W'(ACCESS_LATENCY - 1);
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Word storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end

  // Control and response registers; reset drops anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state is updated only with non-blocking assignments so all flops sample together.
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_read_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_write_q <= rsp_write_d;
      rsp_read_q  <= rsp_read_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_banked_req_memory.sv
// Bench for banked_req_memory: directed scenarios plus randomized traffic
// checked against an in-order behavioural model of the memory.
module tb_banked_req_memory;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;
  localparam int QD    = 4;

  typedef struct packed {
    logic        w;
    logic        r;
    logic        err;
    logic [3:0]  id;
    logic [63:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_write = 1'b0;
  logic        req_read = 1'b0;
  logic [3:0]  req_id = '0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_byte_en = '0;
  logic [63:0] req_write_data = '0;
  logic        rsp_ready = 1'b0;
  logic        mem_ready;
  logic        req_latched;
  logic        rsp_write;
  logic        rsp_read;
  logic        rsp_err;
  logic [3:0]  rsp_id;
  logic [63:0] rsp_read_data;
  logic [2:0]  queue_count;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] model_mem [DEPTH];

  banked_req_memory #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH),
    .ID_WIDTH(4), .QUEUE_DEPTH(QD), .ACCESS_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_write(req_write), .req_read(req_read), .req_id(req_id),
    .req_addr(req_addr), .req_byte_en(req_byte_en), .req_write_data(req_write_data),
    .mem_ready(mem_ready), .req_latched(req_latched),
    .rsp_write(rsp_write), .rsp_read(rsp_read), .rsp_err(rsp_err),
    .rsp_id(rsp_id), .rsp_read_data(rsp_read_data),
    .rsp_ready(rsp_ready), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Apply one request to the model memory and return the response it must produce.
  function automatic rsp_t model_access(input logic wr, input logic [3:0] id,
                                        input logic [31:0] addr, input logic [7:0] be,
                                        input logic [63:0] wd);
    rsp_t r;
    r.w = wr; r.r = !wr; r.id = id; r.data = '0; r.err = (addr >= 32'(DEPTH));
    if (!r.err) begin
      if (wr) begin
        for (int b = 0; b < 8; b++)
          if (be[b]) model_mem[addr[9:0]][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        r.data = model_mem[addr[9:0]];
      end
    end
    return r;
  endfunction

  function automatic rsp_t observe();
    return {rsp_write, rsp_read, rsp_err, rsp_id, rsp_read_data};
  endfunction

  // Present one request for one edge (called at a falling edge); reports acceptance.
  task automatic send(input logic wr, input logic rd, input logic [3:0] id,
                      input logic [31:0] addr, input logic [7:0] be,
                      input logic [63:0] wd, output logic acc);
    req_write = wr; req_read = rd; req_id = id; req_addr = addr;
    req_byte_en = be; req_write_data = wd;
    #1 acc = req_latched;
    @(posedge clk); @(negedge clk);
    req_write = 1'b0; req_read = 1'b0;
  endtask

  // Wait (bounded) for a valid response, capture it, then step past its handshake edge.
  task automatic wait_rsp(output logic got, output rsp_t obs, output time t);
    got = 1'b0; obs = '0; t = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (rsp_write || rsp_read) begin
        got = 1'b1; obs = observe(); t = $time;
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_write = 1'b1;
    #1;
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_mem_ready: got %b exp 0", mem_ready); end
    n_vec++; if (req_latched !== 1'b0) begin n_err++; $display("FAIL rst_latched: got %b exp 0", req_latched); end
    n_vec++; if (observe() !== '0) begin n_err++; $display("FAIL rst_rsp: got %h exp 0", observe()); end
    n_vec++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", queue_count); end
    req_write = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b exp 1", mem_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic acc, got; rsp_t obs, exp; time t0, t1;
    rsp_ready = 1'b1;
    send(1'b1, 1'b0, 4'd3, 32'h10, 8'hFF, 64'h1122334455667788, acc);
    t0 = $time;
    void'(model_access(1'b1, 4'd3, 32'h10, 8'hFF, 64'h1122334455667788));
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %b exp 1", acc); end
    wait_rsp(got, obs, t1);
    exp = '{w: 1'b1, r: 1'b0, err: 1'b0, id: 4'd3, data: 64'h0};
    n_vec++; if (!got || obs !== exp) begin n_err++; $display("FAIL basic_wr_rsp: got %h exp %h (seen %b)", obs, exp, got); end
    n_vec++; if (t1 - t0 !== time'((LAT + 1) * 10)) begin n_err++; $display("FAIL basic_latency: got %0t exp %0d", t1 - t0, (LAT + 1) * 10); end
    n_vec++; if (rsp_write !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle: got %b exp 0", rsp_write); end

    send(1'b0, 1'b1, 4'd4, 32'h10, 8'h00, 64'h0, acc);
    void'(model_access(1'b0, 4'd4, 32'h10, 8'h00, 64'h0));
    wait_rsp(got, obs, t1);
    exp = '{w: 1'b0, r: 1'b1, err: 1'b0, id: 4'd4, data: 64'h1122334455667788};
    n_vec++; if (!got || obs !== exp) begin n_err++; $display("FAIL basic_rd_rsp: got %h exp %h (seen %b)", obs, exp, got); end

    send(1'b1, 1'b0, 4'd5, 32'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB, acc);
    void'(model_access(1'b1, 4'd5, 32'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB));
    wait_rsp(got, obs, t1);
    send(1'b0, 1'b1, 4'd6, 32'h10, 8'h00, 64'h0, acc);
    void'(model_access(1'b0, 4'd6, 32'h10, 8'h00, 64'h0));
    wait_rsp(got, obs, t1);
    exp = '{w: 1'b0, r: 1'b1, err: 1'b0, id: 4'd6, data: 64'h11223344BBBBBBBB};
    n_vec++; if (!got || obs !== exp) begin n_err++; $display("FAIL partial_rd: got %h exp %h (seen %b)", obs, exp, got); end
  endtask

  task automatic test_backpressure();
    rsp_t exp_q[$]; rsp_t obs; logic got; time t_now, t_prev;
    logic [63:0] d;
    rsp_ready = 1'b0;
    t_prev = 0;
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom};
      req_write = 1'b1; req_id = 4'(i); req_addr = 32'h40 + 32'(i);
      req_byte_en = 8'hFF; req_write_data = d;
      #1;
      n_vec++; if (req_latched !== (i < 5)) begin n_err++; $display("FAIL bp_accept_%0d: got %b exp %b", i, req_latched, i < 5); end
      if (req_latched) exp_q.push_back(model_access(1'b1, 4'(i), 32'h40 + 32'(i), 8'hFF, d));
      @(posedge clk); @(negedge clk);
    end
    n_vec++; if (queue_count !== 3'd4) begin n_err++; $display("FAIL bp_full_count: got %0d exp 4", queue_count); end
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b exp 0", mem_ready); end
    n_vec++; if (req_latched !== 1'b0) begin n_err++; $display("FAIL bp_held_off: got %b exp 0", req_latched); end
    for (int s = 0; s < 3; s++) begin
      n_vec++; if (observe() !== exp_q[0]) begin n_err++; $display("FAIL bp_stall_%0d: got %h exp %h", s, observe(), exp_q[0]); end
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b1;
    void'(exp_q.pop_front());
    @(posedge clk); @(negedge clk);
    n_vec++; if (req_latched !== 1'b1) begin n_err++; $display("FAIL bp_id5_accept: got %b exp 1", req_latched); end
    if (req_latched) exp_q.push_back(model_access(1'b1, 4'd5, 32'h45, 8'hFF, d));
    @(posedge clk); @(negedge clk);
    req_write = 1'b0;
    for (int k = 1; k < 6; k++) begin
      wait_rsp(got, obs, t_now);
      n_vec++;
      if (!got || exp_q.size() == 0 || obs !== exp_q[0]) begin
        n_err++; $display("FAIL bp_order_%0d: got %h exp id %0d (seen %b)", k, obs, k, got);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (k > 1) begin
        n_vec++; if (t_now - t_prev !== time'((LAT + 1) * 10)) begin n_err++; $display("FAIL bp_spacing_%0d: got %0t exp %0d", k, t_now - t_prev, (LAT + 1) * 10); end
      end
      t_prev = t_now;
    end
  endtask

  task automatic test_both_high();
    int seen = 0;
    rsp_ready = 1'b1;
    req_write = 1'b1; req_read = 1'b1; req_id = 4'd2; req_addr = 32'h10;
    #1;
    n_vec++; if (req_latched !== 1'b0) begin n_err++; $display("FAIL both_latched: got %b exp 0", req_latched); end
    @(posedge clk); @(negedge clk);
    n_vec++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL both_count: got %0d exp 0", queue_count); end
    req_write = 1'b0; req_read = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_write || rsp_read) seen++;
      @(posedge clk); @(negedge clk);
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL both_no_rsp: got %0d exp 0", seen); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [8];
    logic [63:0] datas [8];
    logic acc, got, wr; rsp_t obs, exp; time t;
    addrs = '{32'h0, 32'h5, 32'd1024, 32'd1024, 32'hFFFFFFFF, 32'd1029, 32'h0, 32'h5};
    for (int i = 0; i < 8; i++) datas[i] = {$urandom, $urandom};
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr = !(i == 2 || i >= 6);
      send(wr, !wr, 4'(i + 7), addrs[i], 8'hFF, datas[i], acc);
      exp = model_access(wr, 4'(i + 7), addrs[i], 8'hFF, datas[i]);
      wait_rsp(got, obs, t);
      n_vec++; if (!got || obs !== exp) begin n_err++; $display("FAIL oor_%0d: got %h exp %h (seen %b)", i, obs, exp, got); end
    end
  endtask

  task automatic test_random();
    rsp_t exp_q[$]; logic wr, rd; logic [31:0] a; logic [7:0] be; int pl = 0; int op;
    for (int i = 0; i < 400; i++) begin
      if (pl < 16) begin
        wr = 1'b1; rd = 1'b0; a = 32'h20 + 32'(pl); be = 8'hFF;
      end else begin
        op = $urandom_range(0, 9);
        wr = (op == 0) || (op >= 2 && op <= 5);
        rd = (op == 0) || (op >= 6);
        if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1) ? 32'hFFFFFFFF : 32'd1024 + 32'($urandom_range(0, 100));
        else a = 32'h20 + 32'($urandom_range(0, 15));
        be = 8'($urandom);
      end
      req_write = wr; req_read = rd; req_id = 4'($urandom); req_addr = a;
      req_byte_en = be; req_write_data = {$urandom, $urandom};
      rsp_ready = (pl < 16) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (rsp_write || rsp_read) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rnd_unexpected: got %h exp none", observe()); end
        else if (observe() !== exp_q[0]) begin n_err++; $display("FAIL rnd_rsp_%0d: got %h exp %h", i, observe(), exp_q[0]); end
        if (rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (wr && rd) begin
        n_vec++; if (req_latched !== 1'b0) begin n_err++; $display("FAIL rnd_both_%0d: got %b exp 0", i, req_latched); end
      end
      if (req_latched && (wr ^ rd)) begin
        exp_q.push_back(model_access(wr, req_id, a, be, req_write_data));
        if (pl < 16) pl++;
      end
      @(posedge clk); @(negedge clk);
    end
    req_write = 1'b0; req_read = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      if (rsp_write || rsp_read) begin
        n_vec++;
        if (observe() !== exp_q[0]) begin n_err++; $display("FAIL rnd_drain: got %h exp %h", observe(), exp_q[0]); end
        void'(exp_q.pop_front());
      end
      @(posedge clk); @(negedge clk);
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_outstanding: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_midbusy();
    logic [63:0] old [5]; logic [63:0] new0;
    logic acc, got; rsp_t obs, exp; time t; int seen = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      old[i] = {$urandom, $urandom};
      send(1'b1, 1'b0, 4'(i), 32'h30 + 32'(i), 8'hFF, old[i], acc);
      void'(model_access(1'b1, 4'(i), 32'h30 + 32'(i), 8'hFF, old[i]));
      wait_rsp(got, obs, t);
    end
    rsp_ready = 1'b0;
    new0 = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      req_write = 1'b1; req_id = 4'(i); req_addr = 32'h30 + 32'(i); req_byte_en = 8'hFF;
      req_write_data = (i == 0) ? new0 : ~old[i];
      #1;
      n_vec++; if (req_latched !== 1'b1) begin n_err++; $display("FAIL rm_accept_%0d: got %b exp 1", i, req_latched); end
      // Only the head completes before reset; the other four are dropped.
      if (i == 0) void'(model_access(1'b1, 4'd0, 32'h30, 8'hFF, new0));
      @(posedge clk); @(negedge clk);
    end
    req_write = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_vec++; if (queue_count !== 3'd3) begin n_err++; $display("FAIL rm_count_before: got %0d exp 3", queue_count); end
    #1 reset = 1'b1;
    #1;
    n_vec++; if (observe() !== '0) begin n_err++; $display("FAIL rm_rsp_async: got %h exp 0", observe()); end
    n_vec++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL rm_count_async: got %0d exp 0", queue_count); end
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready_in_reset: got %b exp 0", mem_ready); end
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready_after: got %b exp 1", mem_ready); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_write || rsp_read) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rm_stale: got %0d exp 0", seen); end
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 1'b1, 4'(i + 8), 32'h30 + 32'(i), 8'h00, 64'h0, acc);
      exp = model_access(1'b0, 4'(i + 8), 32'h30 + 32'(i), 8'h00, 64'h0);
      wait_rsp(got, obs, t);
      n_vec++; if (!got || obs !== exp) begin n_err++; $display("FAIL rm_readback_%0d: got %h exp %h (seen %b)", i, obs, exp, got); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_both_high();
    test_out_of_range();
    test_random();
    test_reset_midbusy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
